// File: rtl/nios2_cpu_div_cell_if.sv
// Divider request/response bundle between the E-stage (master) and the
// divider cell (slave).
//   E_src1/E_src2    : dividend / divisor
//   E_div_start      : single-cycle request, operands sampled with it
//   E_div_signed     : 1 = div, 0 = divu
//   E_div_kill       : pipeline flush, aborts an operation in flight
//   M_div_busy       : operation in progress
//   M_div_valid      : one-cycle completion pulse
//   M_div_quot/rem   : results, held until the next completion
//   M_div_by_zero    : divisor was zero, qualified by valid
interface nios2_cpu_div_cell_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] E_src1;
    logic [WIDTH-1:0] E_src2;
    logic             E_div_start;
    logic             E_div_signed;
    logic             E_div_kill;
    logic             M_div_busy;
    logic             M_div_valid;
    logic [WIDTH-1:0] M_div_quot;
    logic [WIDTH-1:0] M_div_rem;
    logic             M_div_by_zero;

    modport master (
        output E_src1, E_src2, E_div_start, E_div_signed, E_div_kill,
        input  M_div_busy, M_div_valid, M_div_quot, M_div_rem, M_div_by_zero
    );

    modport slave (
        input  E_src1, E_src2, E_div_start, E_div_signed, E_div_kill,
        output M_div_busy, M_div_valid, M_div_quot, M_div_rem, M_div_by_zero
    );
endinterface

// File: rtl/nios2_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu, one quotient bit per clock.
// Fixed 34-clock latency from start-accept edge to the valid pulse.
// Ports:
//   clk   : CPU clock
//   reset : synchronous, active-high
//   bus   : slave side of nios2_cpu_div_cell_if (operands, control, results)
module nios2_cpu_div_cell #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic                  clk,
    input logic                  reset,
    nios2_cpu_div_cell_if.slave  bus
);

    localparam int unsigned      MSB  = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             kill_act;

    logic [WIDTH-1:0] dvd;      // dividend magnitude, becomes quotient as it shifts
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] prem;     // partial remainder
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             busy;
    logic             valid;
    logic             by_zero;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return WIDTH'(0) - x;
    endfunction

    // Trial subtraction; when it succeeds the difference is below the
    // divisor, so the low WIDTH bits are exact.
    assign shifted = {prem, dvd[MSB]};
    assign ge      = shifted >= {1'b0, dvs};
    assign diff    = shifted[WIDTH-1:0] - dvs;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; kill overrides every non-idle transition, and also
    // suppresses a start arriving in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        kill_act  = bus.E_div_kill && (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.E_div_start && !bus.E_div_kill) begin
                    state_nxt = LOAD;
                    accept    = 1'b1;
                end
            end
            LOAD:    state_nxt = ITER;
            ITER:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill_act) begin
            state_nxt = IDLE;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd     <= '0;
            dvs     <= '0;
            prem    <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            by_zero <= 1'b0;
            quot    <= '0;
            rem     <= '0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                dvd  <= bus.E_src1;
                dvs  <= bus.E_src2;
                sgn  <= bus.E_div_signed;
                busy <= 1'b1;
            end
            if (kill_act) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        dvd   <= (sgn && dvd[MSB]) ? neg(dvd) : dvd;
                        dvs   <= (sgn && dvs[MSB]) ? neg(dvs) : dvs;
                        neg_q <= sgn && (dvd[MSB] ^ dvs[MSB]);
                        neg_r <= sgn && dvd[MSB];
                        dz    <= (dvs == '0);
                        prem  <= '0;
                        cnt   <= '0;
                    end
                    ITER: begin
                        prem <= ge ? diff : shifted[WIDTH-1:0];
                        dvd  <= {dvd[MSB-1:0], ge};
                        cnt  <= cnt + CNT_W'(1);
                    end
                    FIX: begin
                        // Divide-by-zero quotient is all ones, never sign-fixed.
                        quot    <= dz ? '1 : (neg_q ? neg(dvd) : dvd);
                        rem     <= neg_r ? neg(prem) : prem;
                        by_zero <= dz;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.M_div_busy    = busy;
    assign bus.M_div_valid   = valid;
    assign bus.M_div_quot    = quot;
    assign bus.M_div_rem     = rem;
    assign bus.M_div_by_zero = by_zero;

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Directed testbench for nios2_cpu_div_cell: latency, signed/unsigned
// results, overflow, divide-by-zero, busy-start, back-to-back, kill, reset.
module tb_nios2_cpu_div_cell;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    nios2_cpu_div_cell_if #(.WIDTH(32)) bus ();

    nios2_cpu_div_cell #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Start pulse sampled at edge N; returns #1 into cycle 1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        bus.E_src1       = a;
        bus.E_src2       = b;
        bus.E_div_signed = s;
        bus.E_div_start  = 1'b1;
        @(posedge clk); #1;
        bus.E_div_start  = 1'b0;
    endtask

    // Counts cycles (sampled at negedge) until valid; -1 on timeout.
    task automatic wait_valid(output int lat, output int drops);
        lat   = -1;
        drops = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.M_div_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.M_div_busy !== 1'b1) drops++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.M_div_busy); end
        vectors++; if (bus.M_div_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", bus.M_div_valid); end
        vectors++; if (bus.M_div_quot !== 32'h0) begin errors++; $display("FAIL reset quot: got %h expected 0", bus.M_div_quot); end
        vectors++; if (bus.M_div_rem !== 32'h0) begin errors++; $display("FAIL reset rem: got %h expected 0", bus.M_div_rem); end
        vectors++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset by_zero: got %b expected 0", bus.M_div_by_zero); end
        reset = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat, drops;
        launch(32'd100, 32'd7, 1'b0);
        wait_valid(lat, drops);
        vectors++; if (lat != 35) begin errors++; $display("FAIL udiv latency: got %0d expected 35", lat); end
        vectors++; if (drops != 0) begin errors++; $display("FAIL udiv busy gap: got %0d low cycles expected 0", drops); end
        vectors++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL udiv busy at valid: got %b expected 0", bus.M_div_busy); end
        vectors++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL udiv quot: got %h expected %h", bus.M_div_quot, 32'd14); end
        vectors++; if (bus.M_div_rem !== 32'd2) begin errors++; $display("FAIL udiv rem: got %h expected %h", bus.M_div_rem, 32'd2); end
        vectors++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL udiv by_zero: got %b expected 0", bus.M_div_by_zero); end
        @(negedge clk);
        vectors++; if (bus.M_div_valid !== 1'b0) begin errors++; $display("FAIL udiv valid pulse width: got %b expected 0", bus.M_div_valid); end
        vectors++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL udiv quot hold: got %h expected %h", bus.M_div_quot, 32'd14); end
    endtask

    task automatic test_signed;
        logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] tb [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002};
        logic        ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eq [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000003, 32'h7FFFFFFC};
        logic [31:0] er [4] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
        int lat, drops;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], ts[i]);
            wait_valid(lat, drops);
            vectors++; if (lat != 35) begin errors++; $display("FAIL signed[%0d] latency: got %0d expected 35", i, lat); end
            vectors++; if (bus.M_div_quot !== eq[i]) begin errors++; $display("FAIL signed[%0d] quot: got %h expected %h", i, bus.M_div_quot, eq[i]); end
            vectors++; if (bus.M_div_rem !== er[i]) begin errors++; $display("FAIL signed[%0d] rem: got %h expected %h", i, bus.M_div_rem, er[i]); end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] ta [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] tb [4] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
        logic        ts [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] eq [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        logic [31:0] er [4] = '{32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000};
        int lat, drops;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], ts[i]);
            wait_valid(lat, drops);
            vectors++; if (bus.M_div_quot !== eq[i]) begin errors++; $display("FAIL ovf[%0d] quot: got %h expected %h", i, bus.M_div_quot, eq[i]); end
            vectors++; if (bus.M_div_rem !== er[i]) begin errors++; $display("FAIL ovf[%0d] rem: got %h expected %h", i, bus.M_div_rem, er[i]); end
            vectors++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf[%0d] by_zero: got %b expected 0", i, bus.M_div_by_zero); end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] ta [4] = '{32'h12345678, 32'h12345678, 32'h87654321, 32'h00000000};
        logic        ts [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int lat, drops;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], 32'h0, ts[i]);
            wait_valid(lat, drops);
            vectors++; if (lat != 35) begin errors++; $display("FAIL dz[%0d] latency: got %0d expected 35", i, lat); end
            vectors++; if (bus.M_div_quot !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz[%0d] quot: got %h expected ffffffff", i, bus.M_div_quot); end
            vectors++; if (bus.M_div_rem !== ta[i]) begin errors++; $display("FAIL dz[%0d] rem: got %h expected %h", i, bus.M_div_rem, ta[i]); end
            vectors++; if (bus.M_div_by_zero !== 1'b1) begin errors++; $display("FAIL dz[%0d] by_zero: got %b expected 1", i, bus.M_div_by_zero); end
        end
    endtask

    task automatic test_busy_start;
        int lat = -1;
        int extra = 0;
        launch(32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.M_div_valid === 1'b1) begin lat = k; break; end
            if (k == 10) begin
                // Second request while busy must be dropped.
                bus.E_src1 = 32'd50; bus.E_src2 = 32'd5; bus.E_div_start = 1'b1;
            end
            if (k == 11) bus.E_div_start = 1'b0;
        end
        vectors++; if (lat != 35) begin errors++; $display("FAIL busy_start latency: got %0d expected 35", lat); end
        vectors++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL busy_start quot: got %h expected %h", bus.M_div_quot, 32'd14); end
        vectors++; if (bus.M_div_rem !== 32'd2) begin errors++; $display("FAIL busy_start rem: got %h expected %h", bus.M_div_rem, 32'd2); end
        vectors++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL busy_start by_zero: got %b expected 0", bus.M_div_by_zero); end
        repeat (40) begin @(negedge clk); if (bus.M_div_valid === 1'b1) extra++; end
        vectors++; if (extra != 0) begin errors++; $display("FAIL busy_start extra valid: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat, drops;
        launch(32'd100, 32'd7, 1'b0);
        wait_valid(lat, drops);
        vectors++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL b2b first quot: got %h expected %h", bus.M_div_quot, 32'd14); end
        // Start during the valid cycle; sampled at the edge that ends it.
        bus.E_src1 = 32'd1000; bus.E_src2 = 32'd10; bus.E_div_signed = 1'b0; bus.E_div_start = 1'b1;
        @(posedge clk); #1;
        bus.E_div_start = 1'b0;
        wait_valid(lat, drops);
        vectors++; if (lat != 35) begin errors++; $display("FAIL b2b second latency: got %0d expected 35", lat); end
        vectors++; if (drops != 0) begin errors++; $display("FAIL b2b busy gap: got %0d low cycles expected 0", drops); end
        vectors++; if (bus.M_div_quot !== 32'd100) begin errors++; $display("FAIL b2b second quot: got %h expected %h", bus.M_div_quot, 32'd100); end
        vectors++; if (bus.M_div_rem !== 32'd0) begin errors++; $display("FAIL b2b second rem: got %h expected 0", bus.M_div_rem); end
    endtask

    task automatic test_kill;
        int lat, drops;
        int extra = 0;
        launch(32'd100, 32'd7, 1'b0);
        wait_valid(lat, drops);
        launch(32'd1000, 32'd3, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 20) bus.E_div_kill = 1'b1;
        end
        bus.E_div_kill = 1'b0;
        vectors++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL kill busy: got %b expected 0", bus.M_div_busy); end
        repeat (40) begin @(negedge clk); if (bus.M_div_valid === 1'b1) extra++; end
        vectors++; if (extra != 0) begin errors++; $display("FAIL kill valid: got %0d pulses expected 0", extra); end
        vectors++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL kill quot hold: got %h expected %h", bus.M_div_quot, 32'd14); end
        vectors++; if (bus.M_div_rem !== 32'd2) begin errors++; $display("FAIL kill rem hold: got %h expected %h", bus.M_div_rem, 32'd2); end
        // Kill together with start in IDLE drops the start.
        bus.E_div_start = 1'b1; bus.E_div_kill = 1'b1;
        @(posedge clk); #1;
        bus.E_div_start = 1'b0; bus.E_div_kill = 1'b0;
        @(negedge clk);
        vectors++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL kill+start busy: got %b expected 0", bus.M_div_busy); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (bus.M_div_valid === 1'b1) extra++; end
        vectors++; if (extra != 0) begin errors++; $display("FAIL kill+start valid: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat, drops;
        int extra = 0;
        launch(32'd1000, 32'd3, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) reset = 1'b1;
        end
        reset = 1'b0;
        vectors++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", bus.M_div_busy); end
        vectors++; if (bus.M_div_quot !== 32'h0) begin errors++; $display("FAIL rst_mid quot: got %h expected 0", bus.M_div_quot); end
        vectors++; if (bus.M_div_rem !== 32'h0) begin errors++; $display("FAIL rst_mid rem: got %h expected 0", bus.M_div_rem); end
        repeat (40) begin @(negedge clk); if (bus.M_div_valid === 1'b1) extra++; end
        vectors++; if (extra != 0) begin errors++; $display("FAIL rst_mid valid: got %0d pulses expected 0", extra); end
        launch(32'd100, 32'd7, 1'b0);
        wait_valid(lat, drops);
        vectors++; if (lat != 35) begin errors++; $display("FAIL rst_mid restart latency: got %0d expected 35", lat); end
        vectors++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL rst_mid restart quot: got %h expected %h", bus.M_div_quot, 32'd14); end
        vectors++; if (bus.M_div_rem !== 32'd2) begin errors++; $display("FAIL rst_mid restart rem: got %h expected %h", bus.M_div_rem, 32'd2); end
    endtask

    initial begin
        reset            = 1'b1;
        bus.E_src1       = '0;
        bus.E_src2       = '0;
        bus.E_div_start  = 1'b0;
        bus.E_div_signed = 1'b0;
        bus.E_div_kill   = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_busy_start();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nios2_cpu_div_cell.md
Name: nios2_cpu_div_cell

Overview:
- Iterative 32-bit integer divider for the Nios II gen2 CPU execute/memory stages. It is the inverse arithmetic path to the multiplier partial-product cell.
- It accepts dividend/divisor from E-stage source operands and runs a radix-2 restoring division, one quotient bit per clock.
- It returns quotient and remainder with a valid pulse, and holds busy so the pipeline stalls.
- It serves div/divu. The remainder is exported for the future rem-emulation path.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported by the CPU, other values are for unit test only.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  CPU clock.
- reset  in  1  synchronous, active-high reset.
- E_src1  in  WIDTH  dividend.
- E_src2  in  WIDTH  divisor.
- E_div_start  in  1  single-cycle request; operands are sampled with it.
- E_div_signed  in  1  1 = div (two's complement), 0 = divu; sampled with start.
- E_div_kill  in  1  pipeline flush; aborts the operation in progress.
- M_div_busy  out  1  high from the start-accept edge until the result is valid.
- M_div_valid  out  1  one-cycle completion pulse.
- M_div_quot  out  WIDTH  quotient.
- M_div_rem  out  WIDTH  remainder.
- M_div_by_zero  out  1  divisor was zero; qualified by valid.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high.
  - On reset: state IDLE; busy, valid, by_zero = 0; quot, rem = 0; counter = 0.
- States: IDLE, LOAD, ITER, FIX.
- IDLE:
  - E_div_start = 1 at edge N accepts the operation.
  - Capture src1, src2 and signed; go to LOAD.
  - Busy goes high after edge N.
- LOAD (edge N+1):
  - If signed, register |src1| and |src2|, and record neg_q = src1[31]^src2[31] and neg_r = src1[31].
  - Clear the partial remainder; set counter = 0; set by_zero = (src2 == 0); go to ITER.
- ITER (edges N+2 .. N+33, 32 cycles):
  - Shift {rem, dvd} left by 1 and trial-subtract the divisor from the (WIDTH+1)-bit partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments each cycle; go to FIX after counter == WIDTH-1.
- FIX (edge N+34):
  - Apply signs: quot = neg_q ? -q : q; rem = neg_r ? -r : r.
  - Load M_div_quot and M_div_rem, pulse valid, drop busy, return to IDLE.
- Latency: start at edge N gives valid high for exactly the cycle following edge N+34. Total latency is 34 clocks, fixed for all operands including divide-by-zero.
- Output hold: quot, rem and by_zero hold their values until the next FIX edge. Valid is low except for the single pulse.
- Divide by zero: quot = 0xFFFFFFFF for both signed and unsigned (the signed case is forced, no sign fix); rem = src1 unchanged; by_zero = 1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quot = 0x80000000, rem = 0, by_zero = 0. This falls out of the 32-bit wrap of the unsigned magnitude 0x80000000; no special case.
- Remainder sign always follows the dividend; zero magnitude stays 0.
- Start while busy is ignored; no queueing.
- Start in the same cycle as the valid pulse is accepted, since the state is IDLE by then. Busy is therefore re-asserted immediately.
- Kill:
  - E_div_kill while in LOAD, ITER or FIX returns to IDLE at the next edge.
  - No valid pulse is produced; busy = 0; outputs keep their previous values.
  - Kill in IDLE has no effect.
  - Kill and start together in IDLE: kill wins, start is dropped.
- Reset mid-operation: behaves as a full reset (outputs cleared); no valid pulse.

Test Plan:
- Unsigned 100 / 7, start at cycle 0: busy 1 for cycles 1-34; valid only in cycle 35; quot = 14, rem = 2, by_zero = 0.
- Signed 0xFFFFFFF9 (-7) / 2: quot = 0xFFFFFFFD (-3), rem = 0xFFFFFFFF (-1). Signed 7 / -2: quot = 0xFFFFFFFD, rem = 1.
- Signed 0x80000000 / 0xFFFFFFFF gives quot = 0x80000000, rem = 0. Unsigned 0xFFFFFFFF / 1 gives quot = 0xFFFFFFFF, rem = 0.
- Divisor 0, dividend 0x12345678, both signed modes: after 34 clocks, quot = 0xFFFFFFFF, rem = 0x12345678, by_zero = 1.
- Second start at cycle 10 is ignored (first result still 100/7 = 14). Back-to-back start in the valid cycle yields a second valid 34 cycles later.
- Kill at cycle 20: busy 0 at cycle 21, no valid, quot/rem retain old values. Reset at cycle 15: all outputs 0 the next cycle, no valid. A subsequent start works normally.
